// File: rtl/jpeg_pkg.sv
// Shared types and limits for the JPEG DHT table builder.
// Used by the table builder top and its canonical code generator.
package jpeg_pkg;

   localparam int NUM_CODE_LENGTHS = 16;
   localparam int MAX_DC_SYMS      = 12;
   localparam int MAX_AC_SYMS      = 162;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_COUNTS,
      S_SYMS,
      S_ADV,
      S_TBL_END,
      S_ERR
   } dht_state_t;

   typedef enum logic [1:0] {
      E_BAD_HDR  = 2'd0,
      E_TOO_MANY = 2'd1,
      E_OVERFLOW = 2'd2,
      E_TRUNC    = 2'd3
   } dht_err_t;

   typedef struct packed {
      logic        cls;
      logic [1:0]  id;
      logic [4:0]  len;
      logic [15:0] code;
      logic [7:0]  symbol;
      logic [7:0]  index;
   } dht_wr_t;

endpackage

// File: rtl/dht_code_gen.sv
// Canonical Huffman code/length counter with overflow detection.
// Code keeps one extra bit so code >= 2^len is visible.
module dht_code_gen
   import jpeg_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        init_i,
   input  logic        inc_i,
   input  logic        next_len_i,
   output logic [15:0] code_o,
   output logic [4:0]  len_o,
   output logic        overflow_o
);

   logic [16:0] code_q, code_d, base;
   logic [4:0]  len_q, len_d;

   always_comb begin
      base   = inc_i ? code_q + 17'd1 : code_q;
      code_d = base;
      len_d  = len_q;
      if (init_i) begin
         code_d = '0;
         len_d  = 5'd1;
      end else if (next_len_i && len_q != 5'(NUM_CODE_LENGTHS)) begin
         code_d = {base[15:0], 1'b0};
         len_d  = len_q + 5'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code_q <= '0;
         len_q  <= '0;
      end else begin
         code_q <= code_d;
         len_q  <= len_d;
      end
   end

   assign code_o     = code_q[15:0];
   assign len_o      = len_q;
   assign overflow_o = (code_q >> len_q) != 17'd0;

endmodule

// File: rtl/dht_table_builder.sv
// Parses DHT segment payloads and emits one canonical Huffman code
// write per symbol toward the entropy decoder's table memory.
module dht_table_builder
   import jpeg_pkg::*;
#(
   parameter int BYTE_W   = 8,
   parameter int MAX_SYMS = 256
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [15:0]                 seg_len,
   output logic                        busy,
   input  logic [BYTE_W-1:0]           in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic                        wr_valid,
   input  logic                        wr_ready,
   output logic                        wr_class,
   output logic [1:0]                  wr_id,
   output logic [4:0]                  wr_len,
   output logic [15:0]                 wr_code,
   output logic [7:0]                  wr_symbol,
   output logic [$clog2(MAX_SYMS)-1:0] wr_index,
   output logic                        tbl_done,
   output logic [12:0]                 tbl_bits,
   output logic                        seg_done,
   output logic                        err,
   output logic [1:0]                  err_code
);

   localparam int IW = $clog2(MAX_SYMS);

   dht_state_t  state_q;
   logic [15:0] rem_bytes_q;
   logic        cls_q;
   logic [1:0]  id_q;
   logic [3:0]  cidx_q;
   logic [7:0]  count_q [NUM_CODE_LENGTHS];
   logic [11:0] nsyms_q, nsyms_d;
   logic [12:0] bits_q, bits_d;
   logic [IW-1:0] idx_q;
   logic [7:0]  rem_q;
   logic        wr_valid_q;
   dht_wr_t     wr_q;
   logic        busy_q, tbl_done_q, seg_done_q, err_q;
   logic [12:0] tbl_bits_q;
   dht_err_t    err_code_q, err_sel;

   logic        acc, slot_free, last_byte, too_many, bad_hdr, cnt_last;
   logic        adv_hit, last_sym, last_of_len, sym_ok, err_det;
   logic [4:0]  len_cnt;
   logic [3:0]  lidx;
   logic        gen_init, gen_inc, gen_next_len, gen_ovf;
   logic [15:0] gen_code;
   logic [4:0]  gen_len;

   dht_code_gen u_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .init_i     (gen_init),
      .inc_i      (gen_inc),
      .next_len_i (gen_next_len),
      .code_o     (gen_code),
      .len_o      (gen_len),
      .overflow_o (gen_ovf)
   );

   always_comb begin
      slot_free = !wr_valid_q || wr_ready;
      in_ready  = 1'b0;
      unique case (state_q)
         S_HDR, S_COUNTS: in_ready = rem_bytes_q != '0;
         S_SYMS: in_ready = rem_bytes_q != '0 && rem_q != '0 && slot_free;
         default: in_ready = 1'b0;
      endcase
   end

   assign acc         = in_valid && in_ready;
   assign last_byte   = rem_bytes_q == 16'd1;
   assign len_cnt     = {1'b0, cidx_q} + 5'd1;
   assign nsyms_d     = nsyms_q + 12'(in_data);
   assign bits_d      = bits_q + 13'(len_cnt) * 13'(in_data);
   assign too_many    = cls_q ? nsyms_d > 12'(MAX_AC_SYMS)
                              : nsyms_d > 12'(MAX_DC_SYMS);
   assign bad_hdr     = in_data[7:4] > 4'd1 || in_data[3:0] > 4'd3;
   assign cnt_last    = cidx_q == 4'(NUM_CODE_LENGTHS - 1);
   assign lidx        = 4'(gen_len - 5'd1);
   assign adv_hit     = count_q[lidx] != '0 ||
                        gen_len == 5'(NUM_CODE_LENGTHS);
   assign last_sym    = 12'(idx_q) + 12'd1 == nsyms_q;
   assign last_of_len = rem_q == 8'd1;
   assign sym_ok      = state_q == S_SYMS && acc && !gen_ovf;

   assign gen_init     = state_q == S_COUNTS && acc && cnt_last;
   assign gen_inc      = sym_ok;
   assign gen_next_len = (state_q == S_ADV && !adv_hit) ||
                         (sym_ok && last_of_len && !last_sym);

   // A byte that empties the segment is only fatal if the table is unfinished.
   always_comb begin
      err_det = 1'b0;
      err_sel = E_BAD_HDR;
      if (acc) begin
         unique case (state_q)
            S_HDR: begin
               if (bad_hdr) begin
                  err_det = 1'b1;
                  err_sel = E_BAD_HDR;
               end else if (last_byte) begin
                  err_det = 1'b1;
                  err_sel = E_TRUNC;
               end
            end
            S_COUNTS: begin
               if (cnt_last && too_many) begin
                  err_det = 1'b1;
                  err_sel = E_TOO_MANY;
               end else if (last_byte && !(cnt_last && nsyms_d == '0)) begin
                  err_det = 1'b1;
                  err_sel = E_TRUNC;
               end
            end
            S_SYMS: begin
               if (gen_ovf) begin
                  err_det = 1'b1;
                  err_sel = E_OVERFLOW;
               end else if (last_byte && !last_sym) begin
                  err_det = 1'b1;
                  err_sel = E_TRUNC;
               end
            end
            default: err_det = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rem_bytes_q <= '0;
         cls_q       <= 1'b0;
         id_q        <= '0;
         cidx_q      <= '0;
         nsyms_q     <= '0;
         bits_q      <= '0;
         idx_q       <= '0;
         rem_q       <= '0;
         for (int i = 0; i < NUM_CODE_LENGTHS; i++) count_q[i] <= '0;
         wr_valid_q  <= 1'b0;
         wr_q        <= '0;
         busy_q      <= 1'b0;
         tbl_done_q  <= 1'b0;
         tbl_bits_q  <= '0;
         seg_done_q  <= 1'b0;
         err_q       <= 1'b0;
         err_code_q  <= E_BAD_HDR;
      end else begin
         tbl_done_q <= 1'b0;
         seg_done_q <= 1'b0;
         err_q      <= 1'b0;
         if (acc) rem_bytes_q <= rem_bytes_q - 16'd1;
         if (wr_valid_q && wr_ready) wr_valid_q <= 1'b0;
         if (sym_ok) begin
            wr_valid_q <= 1'b1;
            wr_q <= '{cls: cls_q, id: id_q, len: gen_len, code: gen_code,
                      symbol: 8'(in_data), index: 8'(idx_q)};
            idx_q <= idx_q + 1'b1;
            rem_q <= rem_q - 8'd1;
         end
         if (err_det) begin
            state_q    <= S_ERR;
            err_q      <= 1'b1;
            err_code_q <= err_sel;
            busy_q     <= 1'b0;
         end else begin
            unique case (state_q)
               S_IDLE: begin
                  if (start) begin
                     if (seg_len == '0) begin
                        seg_done_q <= 1'b1;
                     end else begin
                        rem_bytes_q <= seg_len;
                        busy_q      <= 1'b1;
                        state_q     <= S_HDR;
                     end
                  end
               end
               S_HDR: begin
                  if (acc) begin
                     cls_q   <= in_data[4];
                     id_q    <= in_data[1:0];
                     cidx_q  <= '0;
                     nsyms_q <= '0;
                     bits_q  <= '0;
                     idx_q   <= '0;
                     state_q <= S_COUNTS;
                  end
               end
               S_COUNTS: begin
                  if (acc) begin
                     count_q[cidx_q] <= 8'(in_data);
                     nsyms_q <= nsyms_d;
                     bits_q  <= bits_d;
                     cidx_q  <= cidx_q + 4'd1;
                     if (cnt_last)
                        state_q <= (nsyms_d == '0) ? S_TBL_END : S_ADV;
                  end
               end
               S_ADV: begin
                  if (adv_hit) begin
                     rem_q   <= count_q[lidx];
                     state_q <= S_SYMS;
                  end
               end
               S_SYMS: begin
                  if (acc) begin
                     if (last_sym) state_q <= S_TBL_END;
                     else if (last_of_len) state_q <= S_ADV;
                  end
               end
               S_TBL_END: begin
                  if (!wr_valid_q) begin
                     tbl_done_q <= 1'b1;
                     tbl_bits_q <= bits_q;
                     if (rem_bytes_q == '0) begin
                        seg_done_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                     end else begin
                        state_q <= S_HDR;
                     end
                  end
               end
               S_ERR: state_q <= S_IDLE;
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign busy      = busy_q;
   assign wr_valid  = wr_valid_q;
   assign wr_class  = wr_q.cls;
   assign wr_id     = wr_q.id;
   assign wr_len    = wr_q.len;
   assign wr_code   = wr_q.code;
   assign wr_symbol = wr_q.symbol;
   assign wr_index  = wr_q.index[IW-1:0];
   assign tbl_done  = tbl_done_q;
   assign tbl_bits  = tbl_bits_q;
   assign seg_done  = seg_done_q;
   assign err       = err_q;
   assign err_code  = err_code_q;

endmodule

// File: tb/tb_dht_table_builder.sv
// Directed bench for dht_table_builder: tables, backpressure, errors,
// zero-length segment, start while busy and asynchronous reset.
module tb_dht_table_builder;

   logic        clk = 1'b0;
   logic        rst_n, start, in_valid, wr_ready;
   logic [15:0] seg_len;
   logic [7:0]  in_data;
   logic        busy, in_ready, wr_valid, wr_class;
   logic [1:0]  wr_id, err_code;
   logic [4:0]  wr_len;
   logic [15:0] wr_code;
   logic [7:0]  wr_symbol, wr_index;
   logic        tbl_done, seg_done, err;
   logic [12:0] tbl_bits;

   dht_table_builder dut (
      .clk(clk), .rst_n(rst_n), .start(start), .seg_len(seg_len),
      .busy(busy), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_class(wr_class), .wr_id(wr_id), .wr_len(wr_len),
      .wr_code(wr_code), .wr_symbol(wr_symbol), .wr_index(wr_index),
      .tbl_done(tbl_done), .tbl_bits(tbl_bits), .seg_done(seg_done),
      .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n_tbl, n_seg, n_err;
   logic [12:0] last_bits;
   logic [1:0]  last_ecode;
   logic [39:0] wq[$];
   logic [7:0]  tx[$];
   logic        stall_prev = 1'b0;
   logic [39:0] prev_w;
   logic [39:0] cur_w;

   int          dc_cnt [16] = '{0,1,5,1,1,1,1,1,1,0,0,0,0,0,0,0};
   logic [4:0]  dc_len [12] = '{2,3,3,3,3,3,4,5,6,7,8,9};
   logic [15:0] dc_code[12] = '{16'h000,16'h002,16'h003,16'h004,
                                16'h005,16'h006,16'h00E,16'h01E,
                                16'h03E,16'h07E,16'h0FE,16'h1FE};

   assign cur_w = {wr_class, wr_id, wr_len, wr_code, wr_symbol, wr_index};

   task automatic chk(input string tag, input logic [39:0] obs,
                      input logic [39:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            checks++;
            assert ({wr_valid, cur_w} === {1'b1, prev_w}) else begin
               errors++;
               $error("FAIL wr_stable observed=%0h expected=%0h",
                      {wr_valid, cur_w}, {1'b1, prev_w});
            end
         end
         if (wr_valid && wr_ready) wq.push_back(cur_w);
         if (tbl_done) begin n_tbl++; last_bits = tbl_bits; end
         if (seg_done) n_seg++;
         if (err) begin n_err++; last_ecode = err_code; end
         stall_prev = wr_valid && !wr_ready;
         prev_w = cur_w;
      end
   end

   task automatic clear();
      n_tbl = 0; n_seg = 0; n_err = 0;
      wq.delete();
      tx.delete();
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [15:0] len);
      seg_len = len;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic push_dc(input logic [7:0] hdr);
      tx.push_back(hdr);
      for (int i = 0; i < 16; i++) tx.push_back(8'(dc_cnt[i]));
      for (int i = 0; i < 12; i++) tx.push_back(8'(i));
   endtask

   task automatic push_counts(input logic [7:0] hdr, input int l, input int n);
      tx.push_back(hdr);
      for (int i = 1; i <= 16; i++) tx.push_back(i == l ? 8'(n) : 8'd0);
   endtask

   task automatic feed(input bit bp);
      bit got;
      foreach (tx[i]) begin
         in_data = tx[i];
         in_valid = 1'b1;
         got = 1'b0;
         for (int t = 0; t < 40 && !got; t++) begin
            #1;
            got = in_ready;
            @(posedge clk);
            #1;
            if (bp) wr_ready = ~wr_ready;
         end
         checks++;
         assert (got) else begin
            errors++;
            $error("FAIL feed_timeout observed=byte%0d_stuck expected=accept", i);
         end
         if (!got) break;
      end
      in_valid = 1'b0;
   endtask

   task automatic chk_dc(input int base);
      for (int i = 0; i < 12; i++) begin
         if (base + i < wq.size())
            chk($sformatf("dc_wr%0d", i), wq[base+i],
                {1'b0, 2'd0, dc_len[i], dc_code[i], 8'(i), 8'(i)});
         else
            chk("dc_wr_missing", 40'(wq.size()), 40'(base + 12));
      end
   endtask

   task automatic chk_err(input string tag, input logic [1:0] code,
                          input int nwr);
      chk({tag, "_nerr"}, 40'(n_err), 40'd1);
      chk({tag, "_code"}, 40'(last_ecode), 40'(code));
      chk({tag, "_nwr"}, 40'(wq.size()), 40'(nwr));
      chk({tag, "_ntbl"}, 40'(n_tbl + n_seg), 40'd0);
      chk({tag, "_busy"}, 40'(busy), 40'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; seg_len = '0;
      in_data = '0; in_valid = 1'b0; wr_ready = 1'b1;
      n_tbl = 0; n_seg = 0; n_err = 0;
      #12;
      chk("rst_ctrl", {busy, in_ready, wr_valid, tbl_done, seg_done, err},
          40'd0);
      chk("rst_data", {err_code, tbl_bits, wr_code, wr_index}, 40'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // zero-length segment
      clear();
      do_start(16'd0);
      chk("seg0_pulse", {seg_done, busy}, {38'd0, 2'b10});
      wait_cyc(1);
      chk("seg0_clear", 40'(seg_done), 40'd0);
      chk("seg0_count", 40'(n_seg), 40'd1);

      // DC luminance table, second start while busy
      clear();
      push_dc(8'h00);
      do_start(16'd29);
      seg_len = 16'd5;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("busy_ignore", 40'(busy), 40'd1);
      feed(1'b0);
      chk("latency", {wr_valid, wr_symbol}, {31'd0, 1'b1, 8'd11});
      wait_cyc(10);
      chk("dc_nwr", 40'(wq.size()), 40'd12);
      chk_dc(0);
      chk("dc_ntbl", 40'(n_tbl), 40'd1);
      chk("dc_bits", 40'(last_bits), 40'd56);
      chk("dc_nseg", 40'(n_seg), 40'd1);
      chk("dc_nerr", 40'(n_err), 40'd0);
      chk("dc_idle", 40'(busy), 40'd0);

      // two tables in one segment
      clear();
      push_dc(8'h00);
      push_counts(8'h11, 2, 2);
      tx.push_back(8'h01);
      tx.push_back(8'h00);
      do_start(16'd48);
      feed(1'b0);
      wait_cyc(10);
      chk("two_nwr", 40'(wq.size()), 40'd14);
      chk_dc(0);
      if (wq.size() == 14) begin
         chk("ac_wr0", wq[12], {1'b1, 2'd1, 5'd2, 16'd0, 8'h01, 8'd0});
         chk("ac_wr1", wq[13], {1'b1, 2'd1, 5'd2, 16'd1, 8'h00, 8'd1});
      end
      chk("two_ntbl", 40'(n_tbl), 40'd2);
      chk("two_bits", 40'(last_bits), 40'd4);
      chk("two_nseg", 40'(n_seg), 40'd1);

      // backpressure
      clear();
      push_dc(8'h00);
      do_start(16'd29);
      wr_ready = 1'b0;
      feed(1'b1);
      wait_cyc(1);
      wr_ready = 1'b1;
      wait_cyc(10);
      chk("bp_nwr", 40'(wq.size()), 40'd12);
      chk_dc(0);
      chk("bp_ntbl_bits", {n_tbl[3:0], last_bits}, {23'd0, 4'd1, 13'd56});
      chk("bp_nseg", 40'(n_seg), 40'd1);

      // bad Tc/Th
      clear();
      tx.push_back(8'h24);
      do_start(16'd17);
      feed(1'b0);
      wait_cyc(5);
      chk_err("hdr", 2'd0, 0);

      // too many DC symbols
      clear();
      push_counts(8'h00, 2, 13);
      do_start(16'd30);
      feed(1'b0);
      wait_cyc(5);
      chk_err("many", 2'd1, 0);

      // code overflow on the third length-1 symbol
      clear();
      push_counts(8'h00, 1, 3);
      tx.push_back(8'h0A);
      tx.push_back(8'h0B);
      tx.push_back(8'h0C);
      do_start(16'd20);
      feed(1'b0);
      wait_cyc(5);
      chk_err("ovf", 2'd2, 2);
      if (wq.size() == 2)
         chk("ovf_wr1", wq[1], {1'b0, 2'd0, 5'd1, 16'd1, 8'h0B, 8'd1});

      // truncated segment
      clear();
      push_counts(8'h00, 3, 5);
      for (int i = 0; i < 3; i++) tx.push_back(8'(i));
      do_start(16'd20);
      feed(1'b0);
      wait_cyc(5);
      chk_err("trunc", 2'd3, 3);
      if (wq.size() == 3)
         chk("trunc_wr2", wq[2], {1'b0, 2'd0, 5'd3, 16'd2, 8'h02, 8'd2});

      // asynchronous reset in the middle of SYMS
      clear();
      push_dc(8'h00);
      while (tx.size() > 20) void'(tx.pop_back());
      do_start(16'd29);
      feed(1'b0);
      chk("pre_rst", {busy, wr_valid}, {38'd0, 2'b11});
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ctrl",
          {busy, in_ready, wr_valid, tbl_done, seg_done, err}, 40'd0);
      chk("mid_rst_data", {err_code, tbl_bits, wr_code, wr_index}, 40'd0);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      clear();
      push_dc(8'h00);
      do_start(16'd29);
      feed(1'b0);
      wait_cyc(10);
      chk("post_nwr", 40'(wq.size()), 40'd12);
      chk_dc(0);
      chk("post_done", {n_tbl[3:0], n_seg[3:0], last_bits},
          {19'd0, 4'd1, 4'd1, 13'd56});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dht_table_builder.md
Name: dht_table_builder

Overview:
- Sequences construction of canonical Huffman tables from a DHT marker segment.
- Consumes the segment payload as a byte stream and parses one or more tables (Tc/Th byte, 16 BITS counts, HUFFVAL symbols).
- Generates the canonical code for every symbol and issues one write per symbol to the downstream Huffman table memory.
- Reports per-table completion with total code bits, plus segment completion and errors. Sits between the marker parser and the entropy decoder's table RAM.

Parameters:
- BYTE_W, 8, stream byte width.
- MAX_SYMS, 256, symbol index range per table (sets wr_index width).

Ports:
- clk in 1: single clock, rising edge.
- rst_n in 1: asynchronous, active-low reset.
- start in 1: pulse; latches seg_len, begins parse.
- seg_len in 16: payload byte count, excluding the 2 length bytes.
- busy out 1: high from start acceptance until seg_done/err.
- in_data in 8: payload byte.
- in_valid in 1: byte valid.
- in_ready out 1: byte accepted when in_valid & in_ready.
- wr_valid out 1: table write valid.
- wr_ready in 1: table memory accepts.
- wr_class out 1: Tc (0=DC, 1=AC).
- wr_id out 2: Th.
- wr_len out 5: code length 1..16.
- wr_code out 16: canonical code, right-aligned.
- wr_symbol out 8: HUFFVAL byte.
- wr_index out 8: symbol position within table.
- tbl_done out 1: pulse at end of each table.
- tbl_bits out 13: sum of L*count[L] for finished table; valid with tbl_done.
- seg_done out 1: pulse when seg_len bytes are consumed cleanly.
- err out 1: pulse on error.
- err_code out 2: 0 bad Tc/Th, 1 too many symbols, 2 code overflow, 3 truncated segment; valid with err.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; code, len, counters and count registers cleared. Reset mid-operation aborts immediately and emits no pulses.
- start:
  - Accepted only in IDLE; ignored while busy.
  - seg_len=0: seg_done pulses the cycle after start, then IDLE.
- FSM states: IDLE, HDR, COUNTS, SYMS, ADV, TBL_END, ERR.
- HDR:
  - in_ready=1; accept one byte, Tc=[7:4], Th=[3:0].
  - Tc>1 or Th>3 -> ERR(0). Else -> COUNTS.
- COUNTS:
  - in_ready=1; accept 16 bytes into count[1..16].
  - Accumulate nsyms (12b) and bits (13b).
  - After the 16th byte: nsyms>12 (DC) or >162 (AC) -> ERR(1).
  - nsyms=0 -> TBL_END. Else code=0, len=1 -> ADV.
- ADV:
  - If count[len]!=0 or len=16 (with remaining symbols) -> SYMS.
  - Else code<<=1, len++, one cycle per skipped length.
- SYMS:
  - in_ready = rem[len]>0 and the output slot is empty or draining (wr_ready).
  - On accept: if code >= 2^len -> ERR(2).
  - Else register the write: wr_valid next cycle with code/len/symbol/index; then code++, rem--, index++.
  - When rem reaches 0: if all nsyms are emitted -> TBL_END, else code<<=1, len++ -> ADV.
- Output handshake:
  - One-entry output register; write fields stable while wr_valid & !wr_ready.
  - Latency is 1 cycle from symbol acceptance to wr_valid.
  - Sustained throughput is 1 symbol/cycle when wr_ready=1.
- TBL_END:
  - Waits for the output register to drain.
  - Pulses tbl_done with tbl_bits.
  - If bytes remain -> HDR; if exactly 0 remain -> seg_done pulse, IDLE.
- Byte accounting:
  - A remaining-byte counter decrements on every accepted byte.
  - If it reaches 0 in HDR (after first byte), COUNTS, or SYMS before the table completes -> ERR(3).
  - in_ready is never asserted once it is 0.
- ERR:
  - One cycle, err=1 with err_code, then IDLE.
  - Unconsumed bytes are left to the upstream to flush.
  - A pending write still completes.

Decomposition:
- Shared package jpeg_pkg:
  - dht_state_t enum.
  - dht_err_t codes.
  - constants NUM_CODE_LENGTHS=16, MAX_DC_SYMS=12, MAX_AC_SYMS=162.
  - dht_wr_t struct (class, id, len, code, symbol, index).
- Sub-module dht_code_gen:
  - Holds code/len registers.
  - Inputs: init, inc, next_len.
  - Outputs: code, len, overflow (code >= 2^len).

Test Plan:
- Standard DC luminance table: seg_len=29, Tc/Th=0x00, counts 0,1,5,1,1,1,1,1,1,0..., symbols 0..11 -> 12 writes with codes 00, 010, 011, 100, 101, 110, 1110, 11110, 111110, 1111110, 11111110, 111111110; tbl_done with tbl_bits=56; seg_done.
- Two tables in one segment: DC class0/id0 plus AC class1/id1 with counts[2]=2, symbols 0x01, 0x00 (seg_len=29+19=48) -> second table writes code 00 then 01, wr_class=1, wr_id=1; two tbl_done pulses, one seg_done.
- Backpressure: wr_ready toggles 0/1 every cycle during a table -> wr_* stable while stalled; no symbol lost or duplicated; index sequence 0..N-1.
- Errors:
  - Tc/Th=0x24 -> err, code 0.
  - DC counts summing to 13 -> err, code 1.
  - counts[1]=3 -> err, code 2, on the third symbol.
  - seg_len=20 with 5 symbols declared -> err, code 3.
- Boundaries:
  - seg_len=0 -> seg_done the next cycle.
  - start while busy is ignored.
  - rst_n low mid-SYMS -> all outputs 0 asynchronously; a fresh start then parses correctly.
